// File: rtl/timer_ctl_pkg.sv
// timer_ctl_pkg: shared widths, interrupt cause indices and overflow FSM states
package timer_ctl_pkg;
    localparam int WIDTH_DEF   = 32;
    localparam int OVF_W_DEF   = 16;
    localparam int RETRY_DEF   = 15;
    localparam int CAUSE_MATCH = 0;
    localparam int CAUSE_OVF   = 1;
    localparam int CAUSE_CAP   = 2;
    typedef enum logic [1:0] {IDLE, CLEAR, WAIT} state_e;
endpackage

// File: rtl/timer_event_ctrl_sync_rise.sv
// sync_rise: two-flop synchronizer followed by an edge register for rising-edge detect
module sync_rise (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_async,
    output logic o_rise
);
    logic [2:0] sync_q, sync_d;
    // shift the async input through the two sync stages and the edge stage
    always_comb sync_d = {sync_q[1:0], i_async};
    // synchronizer and edge flops
    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) sync_q <= '0;
        else         sync_q <= sync_d;
    assign o_rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/timer_event_ctrl.sv
// timer_event_ctrl: overflow clear handshake, overflow extension, compare/capture events and irq merge
module timer_event_ctrl import timer_ctl_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int OVF_W = OVF_W_DEF,
    parameter int RETRY = RETRY_DEF
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_currentv,
    input  logic             i_overflow,
    output logic             o_clearw,
    input  logic             i_cmp_wr,
    input  logic [WIDTH-1:0] i_cmp_data,
    input  logic             i_capture,
    output logic [WIDTH-1:0] o_capture_v,
    output logic [OVF_W-1:0] o_ovf_count,
    output logic             o_irq,
    output logic [2:0]       o_irq_cause,
    input  logic             i_irq_ack,
    output logic             o_clr_err
);
    localparam int RW = $clog2(RETRY + 1);
    state_e           state_q, state_d;
    logic [RW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d, clearw_q, clearw_d, irq_q, irq_d, cmpv_q, cmpv_d, cap_rise;
    logic [OVF_W-1:0] ovf_q, ovf_d;
    logic [WIDTH-1:0] capv_q, capv_d, cmp_q, cmp_d, prev_q, prev_d;
    logic [2:0]       pend_q, pend_d, ev;
    sync_rise u_cap_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_async (i_capture),
        .o_rise  (cap_rise)
    );
    // new events this cycle; the FSM entering CLEAR from IDLE is the only overflow event
    always_comb begin
        ev              = '0;
        ev[CAUSE_MATCH] = cmpv_q && i_enable && (i_currentv == cmp_q) && (prev_q != cmp_q);
        ev[CAUSE_OVF]   = (state_q == IDLE) && i_overflow && i_enable;
        ev[CAUSE_CAP]   = cap_rise && i_enable;
    end
    // overflow clear FSM next state: pulse clear, wait for the flag to drop, re-pulse after RETRY cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            IDLE:    if (i_overflow) state_d = CLEAR;
            CLEAR:   begin state_d = WAIT; cnt_d = '0; end
            WAIT:    if (!i_overflow) state_d = IDLE;
                     else if (cnt_q == RW'(RETRY)) begin state_d = CLEAR; err_d = 1'b1; end
                     else cnt_d = cnt_q + RW'(1);
            default: state_d = IDLE;
        endcase
    end
    // datapath next values; an event in the ack cycle survives the ack
    always_comb begin
        pend_d   = (i_irq_ack ? 3'b000 : pend_q) | ev;
        irq_d    = |pend_d;
        clearw_d = (state_d == CLEAR);
        ovf_d    = ev[CAUSE_OVF] ? ovf_q + OVF_W'(1) : ovf_q;
        capv_d   = ev[CAUSE_CAP] ? i_currentv : capv_q;
        cmp_d    = i_cmp_wr ? i_cmp_data : cmp_q;
        cmpv_d   = cmpv_q | i_cmp_wr;
        prev_d   = i_currentv;
    end
    // all state and registered outputs
    always_ff @(posedge i_clock or posedge i_reset)
        if (i_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            clearw_q <= 1'b0;
            irq_q    <= 1'b0;
            pend_q   <= '0;
            ovf_q    <= '0;
            capv_q   <= '0;
            cmp_q    <= '0;
            cmpv_q   <= 1'b0;
            prev_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            clearw_q <= clearw_d;
            irq_q    <= irq_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            capv_q   <= capv_d;
            cmp_q    <= cmp_d;
            cmpv_q   <= cmpv_d;
            prev_q   <= prev_d;
        end
    assign o_clearw    = clearw_q;
    assign o_irq       = irq_q;
    assign o_irq_cause = pend_q;
    assign o_ovf_count = ovf_q;
    assign o_capture_v = capv_q;
    assign o_clr_err   = err_q;
endmodule

// File: tb/tb_timer_event_ctrl.sv
// tb_timer_event_ctrl: randomized and directed checks of timer_event_ctrl against a behavioural model
module tb_timer_event_ctrl;
    localparam int RETRY = 15;
    logic clk = 1'b0, rst = 1'b1;
    logic en = 0, ovf = 0, cmp_wr = 0, capture = 0, ack = 0;
    logic [31:0] cur = '0, cmp_data = '0;
    logic clearw, irq, err, s_clearw, s_irq, s_err;
    logic [31:0] capv, s_capv;
    logic [15:0] ovf_cnt;
    logic [3:0] s_ovf_cnt;
    logic [2:0] cause, s_cause;
    int n_cmp = 0, n_bad = 0, pulses = 0;
    always #5 clk = ~clk;
    timer_event_ctrl dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_currentv(cur), .i_overflow(ovf),
        .o_clearw(clearw), .i_cmp_wr(cmp_wr), .i_cmp_data(cmp_data), .i_capture(capture),
        .o_capture_v(capv), .o_ovf_count(ovf_cnt), .o_irq(irq), .o_irq_cause(cause),
        .i_irq_ack(ack), .o_clr_err(err)
    );
    timer_event_ctrl #(.OVF_W(4)) dut_small (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_currentv(cur), .i_overflow(ovf),
        .o_clearw(s_clearw), .i_cmp_wr(cmp_wr), .i_cmp_data(cmp_data), .i_capture(capture),
        .o_capture_v(s_capv), .o_ovf_count(s_ovf_cnt), .o_irq(s_irq), .o_irq_cause(s_cause),
        .i_irq_ack(ack), .o_clr_err(s_err)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Model: m_since = cycles since the last clear pulse (-1 = no clear in progress)
    int m_since;
    int unsigned m_ovf;
    logic m_err, m_cv, m_rise, m_ovfe, m_match;
    logic [2:0] m_pend, m_h;
    logic [31:0] m_cap, m_cmp, m_prev;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_since = -1; m_ovf = 0; m_err = 0; m_cv = 0; m_pend = 0; m_h = 0;
            m_cap = 0; m_cmp = 0; m_prev = 0;
        end else begin
            m_ovfe = 0;
            if (m_since < 0) begin
                if (ovf) begin m_since = 0; m_ovfe = en; end
            end else if (m_since == 0) m_since = 1;
            else if (!ovf) m_since = -1;
            else if (m_since == RETRY + 1) begin m_since = 0; m_err = 1; end
            else m_since++;
            m_match = m_cv && en && cur == m_cmp && m_prev != m_cmp;
            m_rise = m_h[1] && !m_h[2] && en;
            m_h = {m_h[1:0], capture};
            m_pend = (ack ? 3'b000 : m_pend) | {m_rise, m_ovfe, m_match};
            if (m_ovfe) m_ovf++;
            if (m_rise) m_cap = cur;
            m_prev = cur;
            if (cmp_wr) begin m_cmp = cmp_data; m_cv = 1; end
        end
    end
    // every-cycle comparison of both instances against the model
    always @(negedge clk) if (!rst) begin
        chk("clearw", 64'(clearw), 64'(m_since == 0));
        chk("irq", 64'(irq), 64'(|m_pend));
        chk("cause", 64'(cause), 64'(m_pend));
        chk("clr_err", 64'(err), 64'(m_err));
        chk("ovf_count", 64'(ovf_cnt), 64'(16'(m_ovf)));
        chk("capture_v", 64'(capv), 64'(m_cap));
        chk("s_ovf_count", 64'(s_ovf_cnt), 64'(4'(m_ovf)));
        chk("s_outputs", {s_capv, 26'b0, s_cause, s_irq, s_err, s_clearw},
            {m_cap, 26'b0, m_pend, |m_pend, m_err, m_since == 0});
    end
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (clearw) pulses++;
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1; en = 0; ovf = 0; cmp_wr = 0; capture = 0; ack = 0; cur = 0; cmp_data = 0;
        step(2);
        rst = 0; pulses = 0; en = 1;
    endtask
    task automatic wait_clear();
        for (int i = 0; i < 40 && !clearw; i++) step(1);
        chk("clearw_seen", 64'(clearw), 64'd1);
    endtask
    initial begin
        step(3);
        rst = 0;
        chk("rst_outputs", {capv, 16'b0, ovf_cnt, 11'b0, cause, irq, err, clearw}, 64'd0);
        // single overflow, flag dropped two cycles after the clear pulse
        do_reset();
        ovf = 1; wait_clear(); step(2); ovf = 0; step(5);
        chk("ovf_pulses", 64'(pulses), 64'd1);
        chk("ovf_count1", 64'(ovf_cnt), 64'd1);
        chk("ovf_cause", 64'(cause), 64'b010);
        chk("ovf_err", 64'(err), 64'd0);
        // flag stuck high for 40 cycles: pulses at cycles 1, 18, 35
        do_reset();
        ovf = 1; step(40); ovf = 0; step(20);
        chk("retry_pulses", 64'(pulses), 64'd3);
        chk("retry_err", 64'(err), 64'd1);
        chk("retry_count", 64'(ovf_cnt), 64'd1);
        // compare at 0x10 with a 5-cycle stall on the value
        do_reset();
        cmp_wr = 1; cmp_data = 32'h10; step(1); cmp_wr = 0;
        for (int v = 0; v < 16; v++) begin cur = v; step(1); end
        cur = 32'h10; step(1);
        chk("match_cause", 64'(cause), 64'b001);
        ack = 1; step(1); ack = 0; step(4);
        chk("match_stall", 64'(cause), 64'd0);
        for (int v = 17; v <= 32; v++) begin cur = v; step(1); end
        chk("match_after", 64'(cause), 64'd0);
        // capture: rising edge seen on the third edge, falling edge ignored
        do_reset();
        cur = 32'hFE; capture = 1; step(1); cur = 32'hFF; step(1); cur = 32'h100; step(1);
        chk("cap_value", 64'(capv), 64'h100);
        chk("cap_cause", 64'(cause), 64'b100);
        cur = 32'h200; ack = 1; step(1); ack = 0; capture = 0; step(5);
        chk("cap_fall", 64'(cause), 64'd0);
        chk("cap_hold", 64'(capv), 64'h100);
        // ack in the same cycle as an overflow event
        do_reset();
        cmp_wr = 1; cmp_data = 5; step(1); cmp_wr = 0; cur = 5; step(1);
        chk("coll_match", 64'(cause), 64'b001);
        ack = 1; ovf = 1; step(1); ack = 0;
        chk("coll_cause", 64'(cause), 64'b010);
        chk("coll_irq", 64'(irq), 64'd1);
        ovf = 0; step(4);
        // 17 overflows: the 4-bit instance wraps to 1
        do_reset();
        repeat (17) begin ovf = 1; step(1); ovf = 0; step(2); end
        chk("wrap_small", 64'(s_ovf_cnt), 64'd1);
        chk("wrap_big", 64'(ovf_cnt), 64'd17);
        // asynchronous reset while the clear pulse is in flight
        ovf = 1; wait_clear();
        #2 rst = 1;
        #1 chk("async_rst", {48'b0, ovf_cnt[7:0], 4'b0, s_ovf_cnt, irq, clearw}, 64'd0);
        step(1); ovf = 0; step(1); rst = 0;
        // randomized traffic
        en = 1;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            en = ($urandom % 16) != 0;
            if ($urandom % 6 == 0) ovf = ~ovf;
            case ($urandom % 4)
                0: ;
                3: cur = $urandom % 32;
                default: cur = cur + 1;
            endcase
            cmp_wr = ($urandom % 20) == 0;
            cmp_data = $urandom_range(0, 31);
            if ($urandom % 8 == 0) capture = ~capture;
            ack = ($urandom % 10) == 0;
        end
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
